clip_gen_responder: RTL and testbench
=====================================

Name: clip_gen_responder

Overview:
- Responder side of the clip-generation command interface used by the tuning FSM. It accepts single-cycle command pulses: make_motion, check_motion, make_detail, check_detail, make_video.
- It models the generation and scoring engine: it latches prompts, spends fixed latencies "generating", returns 8-bit scores with a one-cycle valid strobe, and signals video completion.
- It sits opposite the tuning FSM and serves as both the stand-in engine for system simulation and the protocol checker.

Parameters:
- GEN_CYC, 4, cycles spent in the generate phase (≥1)
- SCORE_CYC, 2, cycles spent in the score phase (≥1)
- RENDER_CYC, 8, cycles spent in the render phase (≥1)
- MOTION_GAIN, 30, offset added to motion_prmt when scoring
- DETAIL_OFFSET, 20, offset added to detail_prmt>>1 when scoring

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- make_motion  in  1  pulse: generate motion clip from motion_prmt
- check_motion  in  1  pulse: score latest motion clip
- make_detail  in  1  pulse: generate detail clip from detail_prmt
- check_detail  in  1  pulse: score latest detail clip
- make_video  in  1  pulse: render final video
- motion_prmt  in  8  motion prompt, sampled with make_motion
- detail_prmt  in  8  detail prompt, sampled with make_detail
- motion_score  out  8  registered motion score, held until the next motion score
- detail_score  out  8  registered detail score, held until the next detail score
- motion_score_valid  out  1  one-cycle strobe, new motion_score
- detail_score_valid  out  1  one-cycle strobe, new detail_score
- video_done  out  1  one-cycle strobe, render complete
- busy  out  1  high while a command is executing
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; latched prompts 0; flags motion_gen, motion_chk, detail_gen, detail_chk cleared. Reset mid-operation aborts the operation; no strobe is ever emitted for an aborted command.
- States: IDLE, GEN, SCORE, RENDER. A 1-bit kind register (MOTION/DETAIL) qualifies GEN and SCORE. A down-counter sized $clog2(max latency+1) times each phase.
- Command acceptance: commands are sampled only in IDLE with exactly one command pulse high.
  - Two or more pulses in the same cycle: err<=1, nothing accepted.
  - Any pulse while busy: err<=1, pulse ignored, current operation unaffected.
- make_motion: latch motion_prmt, kind=MOTION, enter GEN for GEN_CYC cycles, then IDLE. On exit, motion_gen<=1 and motion_chk<=0.
- make_detail: same as make_motion, using detail_prmt and detail_gen/detail_chk.
- check_motion:
  - Requires motion_gen=1; otherwise err<=1 and the pulse is ignored.
  - Enters SCORE for SCORE_CYC cycles.
  - In the cycle after SCORE ends: motion_score updates, motion_score_valid=1 for one cycle, motion_chk<=1, state is IDLE.
- check_detail: same as check_motion, using detail_gen, detail_score, detail_score_valid and detail_chk.
- make_video:
  - Requires motion_chk and detail_chk both 1; otherwise err<=1 and the pulse is ignored.
  - Enters RENDER for RENDER_CYC cycles.
  - In the cycle after RENDER ends, video_done=1 for one cycle and all four flags clear.
- busy: high during every GEN, SCORE and RENDER cycle; low in IDLE, including strobe cycles. A new command may be accepted in a strobe cycle.
- Latency: a command accepted at edge E makes busy high from E for N cycles; the strobe appears in cycle E+N.
- Scoring arithmetic (9-bit intermediate, saturate at 255):
  - motion_score = min(255, motion_prmt + MOTION_GAIN)
  - detail_score = min(255, (detail_prmt >> 1) + DETAIL_OFFSET)
- err is cleared only by reset.

Optional Feature:
- Macro: SCORE_NOISE_EN.
- Defined:
  - An 8-bit Galois LFSR (taps 0xB8, seed 0x01 at reset) advances every clk.
  - Its low 3 bits (0..7) are added to each score before saturation, sampled in the strobe cycle.
- Undefined: no LFSR; scores are exactly the deterministic formulas above.

Decomposition:
- Shared package clip_gen_pkg:
  - state enum (IDLE, GEN, SCORE, RENDER)
  - kind enum
  - SCORE_MAX=255
  - a saturating-add function, shared with the tuning FSM's prompt adjust logic
- One sub-module: clip_gen_lfsr, instantiated only under SCORE_NOISE_EN.

Test Plan:
- make_motion with motion_prmt=50, then check_motion at the first idle cycle: busy high 4 cycles, then 2 cycles; motion_score=80 with motion_score_valid one cycle; err=0.
- make_motion with motion_prmt=240, then check_motion: motion_score=255 (saturated).
- make_detail with detail_prmt=200, then check_detail: detail_score=120. A following make_video gives video_done exactly 8 cycles after acceptance, and the flags clear.
- check_detail with no prior make_detail, and make_video with only motion checked: err=1, no strobes, busy stays 0.
- make_motion during GEN, and make_motion+make_detail in the same idle cycle: err=1, the running operation completes normally, no extra strobe.
- rst low for one cycle in the middle of RENDER: outputs immediately 0; after release, check_motion sets err=1 because the flags were cleared.

Source files
------------

// File: rtl/clip_gen_pkg.sv
// Shared definitions for the clip-generation command interface: state and kind
// encodings, score limit, and the saturating add used by both ends of the link.
package clip_gen_pkg;

  localparam int unsigned SCORE_W   = 8;
  localparam logic [7:0]  SCORE_MAX = 8'd255;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GEN    = 2'd1;
  localparam logic [1:0] ST_SCORE  = 2'd2;
  localparam logic [1:0] ST_RENDER = 2'd3;

  localparam logic KIND_MOTION = 1'b0;
  localparam logic KIND_DETAIL = 1'b1;

  // 9-bit intermediate sum clamped to SCORE_MAX
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/clip_gen_lfsr.sv
// 8-bit Galois LFSR (taps 0xB8, seed 0x01) providing 3-bit score noise.
// Used by clip_gen_responder only when SCORE_NOISE_EN is defined.
module clip_gen_lfsr (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] noise_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ 8'hB8;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'h01;
    else        lfsr_q <= lfsr_d;
  end

  assign noise_o = lfsr_q[2:0];

endmodule

// File: rtl/clip_gen_responder.sv
// Responder/engine model for the clip-generation command interface: accepts
// single-cycle commands, times each phase, returns saturated scores and flags
// protocol misuse. Optional macro SCORE_NOISE_EN adds LFSR noise to scores.
module clip_gen_responder
  import clip_gen_pkg::*;
#(
  parameter int unsigned GEN_CYC       = 4,
  parameter int unsigned SCORE_CYC     = 2,
  parameter int unsigned RENDER_CYC    = 8,
  parameter int unsigned MOTION_GAIN   = 30,
  parameter int unsigned DETAIL_OFFSET = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       make_motion,
  input  logic       check_motion,
  input  logic       make_detail,
  input  logic       check_detail,
  input  logic       make_video,
  input  logic [7:0] motion_prmt,
  input  logic [7:0] detail_prmt,
  output logic [7:0] motion_score,
  output logic [7:0] detail_score,
  output logic       motion_score_valid,
  output logic       detail_score_valid,
  output logic       video_done,
  output logic       busy,
  output logic       err
);

  localparam int unsigned MAX_CYC = (GEN_CYC > SCORE_CYC)
      ? ((GEN_CYC > RENDER_CYC) ? GEN_CYC : RENDER_CYC)
      : ((SCORE_CYC > RENDER_CYC) ? SCORE_CYC : RENDER_CYC);
  localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] GEN_LOAD    = CNT_W'(GEN_CYC - 1);
  localparam logic [CNT_W-1:0] SCORE_LOAD  = CNT_W'(SCORE_CYC - 1);
  localparam logic [CNT_W-1:0] RENDER_LOAD = CNT_W'(RENDER_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic             kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       motion_prmt_q, motion_prmt_d, detail_prmt_q, detail_prmt_d;
  logic             motion_gen_q, motion_gen_d, motion_chk_q, motion_chk_d;
  logic             detail_gen_q, detail_gen_d, detail_chk_q, detail_chk_d;
  logic [7:0]       motion_score_q, motion_score_d, detail_score_q, detail_score_d;
  logic             motion_valid_q, motion_valid_d, detail_valid_q, detail_valid_d;
  logic             video_done_q, video_done_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [4:0] cmd;
  logic       any_cmd;
  logic       multi_cmd;
  logic [7:0] noise;

`ifdef SCORE_NOISE_EN
  logic [2:0] lfsr_bits;

  clip_gen_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst),
    .noise_o (lfsr_bits)
  );

  assign noise = {5'd0, lfsr_bits};
`else
  assign noise = 8'd0;
`endif

  assign cmd       = {make_video, check_detail, make_detail, check_motion, make_motion};
  assign any_cmd   = |cmd;
  assign multi_cmd = |(cmd & (cmd - 5'd1));

  // Next-state and output logic
  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    cnt_d          = cnt_q;
    motion_prmt_d  = motion_prmt_q;
    detail_prmt_d  = detail_prmt_q;
    motion_gen_d   = motion_gen_q;
    motion_chk_d   = motion_chk_q;
    detail_gen_d   = detail_gen_q;
    detail_chk_d   = detail_chk_q;
    motion_score_d = motion_score_q;
    detail_score_d = detail_score_q;
    motion_valid_d = 1'b0;
    detail_valid_d = 1'b0;
    video_done_d   = 1'b0;
    err_d          = err_q;

    if (state_q != ST_IDLE && any_cmd) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (multi_cmd) begin
          err_d = 1'b1;
        end else if (make_motion) begin
          motion_prmt_d = motion_prmt;
          kind_d        = KIND_MOTION;
          state_d       = ST_GEN;
          cnt_d         = GEN_LOAD;
        end else if (make_detail) begin
          detail_prmt_d = detail_prmt;
          kind_d        = KIND_DETAIL;
          state_d       = ST_GEN;
          cnt_d         = GEN_LOAD;
        end else if (check_motion) begin
          if (motion_gen_q) begin
            kind_d  = KIND_MOTION;
            state_d = ST_SCORE;
            cnt_d   = SCORE_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end else if (check_detail) begin
          if (detail_gen_q) begin
            kind_d  = KIND_DETAIL;
            state_d = ST_SCORE;
            cnt_d   = SCORE_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end else if (make_video) begin
          if (motion_chk_q && detail_chk_q) begin
            state_d = ST_RENDER;
            cnt_d   = RENDER_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_GEN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (kind_q == KIND_MOTION) begin
            motion_gen_d = 1'b1;
            motion_chk_d = 1'b0;
          end else begin
            detail_gen_d = 1'b1;
            detail_chk_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SCORE: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (kind_q == KIND_MOTION) begin
            motion_score_d = sat_add(sat_add(motion_prmt_q, 8'(MOTION_GAIN)), noise);
            motion_valid_d = 1'b1;
            motion_chk_d   = 1'b1;
          end else begin
            detail_score_d = sat_add(sat_add({1'b0, detail_prmt_q[7:1]},
                                             8'(DETAIL_OFFSET)), noise);
            detail_valid_d = 1'b1;
            detail_chk_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RENDER: begin
        if (cnt_q == '0) begin
          state_d      = ST_IDLE;
          video_done_d = 1'b1;
          motion_gen_d = 1'b0;
          motion_chk_d = 1'b0;
          detail_gen_d = 1'b0;
          detail_chk_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      kind_q         <= KIND_MOTION;
      cnt_q          <= '0;
      motion_prmt_q  <= '0;
      detail_prmt_q  <= '0;
      motion_gen_q   <= 1'b0;
      motion_chk_q   <= 1'b0;
      detail_gen_q   <= 1'b0;
      detail_chk_q   <= 1'b0;
      motion_score_q <= '0;
      detail_score_q <= '0;
      motion_valid_q <= 1'b0;
      detail_valid_q <= 1'b0;
      video_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      cnt_q          <= cnt_d;
      motion_prmt_q  <= motion_prmt_d;
      detail_prmt_q  <= detail_prmt_d;
      motion_gen_q   <= motion_gen_d;
      motion_chk_q   <= motion_chk_d;
      detail_gen_q   <= detail_gen_d;
      detail_chk_q   <= detail_chk_d;
      motion_score_q <= motion_score_d;
      detail_score_q <= detail_score_d;
      motion_valid_q <= motion_valid_d;
      detail_valid_q <= detail_valid_d;
      video_done_q   <= video_done_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  assign motion_score       = motion_score_q;
  assign detail_score       = detail_score_q;
  assign motion_score_valid = motion_valid_q;
  assign detail_score_valid = detail_valid_q;
  assign video_done         = video_done_q;
  assign busy               = busy_q;
  assign err                = err_q;

endmodule

// File: tb/tb_clip_gen_responder.sv
// Self-checking bench for clip_gen_responder: directed protocol scenarios then
// random command sequences, checked against a command-level reference model.
module tb_clip_gen_responder;

  localparam int GEN_CYC       = 4;
  localparam int SCORE_CYC     = 2;
  localparam int RENDER_CYC    = 8;
  localparam int MOTION_GAIN   = 30;
  localparam int DETAIL_OFFSET = 20;

  // cmd bit positions: 0 make_motion, 1 check_motion, 2 make_detail, 3 check_detail, 4 make_video
  localparam logic [4:0] C_MM = 5'b00001;
  localparam logic [4:0] C_CM = 5'b00010;
  localparam logic [4:0] C_MD = 5'b00100;
  localparam logic [4:0] C_CD = 5'b01000;
  localparam logic [4:0] C_MV = 5'b10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       make_motion, check_motion, make_detail, check_detail, make_video;
  logic [7:0] motion_prmt, detail_prmt;
  logic [7:0] motion_score, detail_score;
  logic       motion_score_valid, detail_score_valid, video_done, busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: protocol flags, latched prompts, held scores, sticky error
  bit m_mgen, m_mchk, m_dgen, m_dchk, m_err;
  int m_mp, m_dp, m_ms, m_ds;

  clip_gen_responder #(
    .GEN_CYC       (GEN_CYC),
    .SCORE_CYC     (SCORE_CYC),
    .RENDER_CYC    (RENDER_CYC),
    .MOTION_GAIN   (MOTION_GAIN),
    .DETAIL_OFFSET (DETAIL_OFFSET)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .make_motion        (make_motion),
    .check_motion       (check_motion),
    .make_detail        (make_detail),
    .check_detail       (check_detail),
    .make_video         (make_video),
    .motion_prmt        (motion_prmt),
    .detail_prmt        (detail_prmt),
    .motion_score       (motion_score),
    .detail_score       (detail_score),
    .motion_score_valid (motion_score_valid),
    .detail_score_valid (detail_score_valid),
    .video_done         (video_done),
    .busy               (busy),
    .err                (err)
  );

  always #5 clk = ~clk;

  function automatic int min255(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] c);
    make_motion  = c[0];
    check_motion = c[1];
    make_detail  = c[2];
    check_detail = c[3];
    make_video   = c[4];
  endtask

  task automatic model_clear();
    m_mgen = 0; m_mchk = 0; m_dgen = 0; m_dchk = 0; m_err = 0;
    m_mp = 0; m_dp = 0; m_ms = 0; m_ds = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mscore"}, 32'(motion_score), 0);
    check({tag, "_dscore"}, 32'(detail_score), 0);
    check({tag, "_mvalid"}, 32'(motion_score_valid), 0);
    check({tag, "_dvalid"}, 32'(detail_score_valid), 0);
    check({tag, "_vdone"}, 32'(video_done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  // Called at a negedge; asserts reset, checks outputs cleared immediately
  task automatic do_reset(input string tag);
    rst = 1'b0;
    drive(5'b0);
    #1;
    check_zero(tag);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Issue command c at the current negedge; optionally pulse inj during busy cycle inj_at.
  // Returns at the negedge of the strobe cycle (or the cycle after an ignored command).
  task automatic issue(input string tag, input logic [4:0] c, input logic [7:0] mp,
                       input logic [7:0] dp, input int inj_at, input logic [4:0] inj);
    int n;
    n = 0;
    motion_prmt = mp;
    detail_prmt = dp;
    drive(c);
    if ($countones(c) == 1) begin
      if (c == C_MM || c == C_MD) n = GEN_CYC;
      else if (c == C_CM && m_mgen) n = SCORE_CYC;
      else if (c == C_CD && m_dgen) n = SCORE_CYC;
      else if (c == C_MV && m_mchk && m_dchk) n = RENDER_CYC;
    end
    if (c != 5'b0 && n == 0) m_err = 1;
    if (n != 0 && c == C_MM) m_mp = int'(mp);
    if (n != 0 && c == C_MD) m_dp = int'(dp);
    @(negedge clk);
    drive(5'b0);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, 32'(busy), 1);
      check({tag, "_mvalid_busy"}, 32'(motion_score_valid), 0);
      check({tag, "_dvalid_busy"}, 32'(detail_score_valid), 0);
      check({tag, "_vdone_busy"}, 32'(video_done), 0);
      if (i == inj_at && inj != 5'b0) begin
        drive(inj);
        m_err = 1;
      end
      @(negedge clk);
      drive(5'b0);
    end
    if (n != 0) begin
      if (c == C_MM) begin m_mgen = 1; m_mchk = 0; end
      if (c == C_MD) begin m_dgen = 1; m_dchk = 0; end
      if (c == C_CM) begin m_ms = min255(m_mp + MOTION_GAIN); m_mchk = 1; end
      if (c == C_CD) begin m_ds = min255(m_dp / 2 + DETAIL_OFFSET); m_dchk = 1; end
      if (c == C_MV) begin m_mgen = 0; m_mchk = 0; m_dgen = 0; m_dchk = 0; end
    end
    check({tag, "_busy_end"}, 32'(busy), 0);
    check({tag, "_mvalid"}, 32'(motion_score_valid), 32'(n != 0 && c == C_CM));
    check({tag, "_dvalid"}, 32'(detail_score_valid), 32'(n != 0 && c == C_CD));
    check({tag, "_vdone"}, 32'(video_done), 32'(n != 0 && c == C_MV));
    check({tag, "_mscore"}, 32'(motion_score), 32'(m_ms));
    check({tag, "_dscore"}, 32'(detail_score), 32'(m_ds));
    check({tag, "_err"}, 32'(err), 32'(m_err));
  endtask

  initial begin
    logic [4:0] c;
    logic [4:0] inj;
    int         r;
    int         a;
    int         b;
    rst = 1'b0;
    drive(5'b0);
    motion_prmt = 8'd0;
    detail_prmt = 8'd0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_zero("por");
    rst = 1'b1;
    @(negedge clk);

    // Main flow: motion 50 -> 80, motion 240 -> 255, detail 200 -> 120, video
    issue("mm50", C_MM, 8'd50, 8'd0, -1, 5'b0);
    issue("cm80", C_CM, 8'd0, 8'd0, -1, 5'b0);
    check("mscore80", 32'(motion_score), 80);
    issue("mm240", C_MM, 8'd240, 8'd0, -1, 5'b0);
    issue("cm255", C_CM, 8'd0, 8'd0, -1, 5'b0);
    check("mscore_sat", 32'(motion_score), 255);
    issue("md200", C_MD, 8'd0, 8'd200, -1, 5'b0);
    issue("cd120", C_CD, 8'd0, 8'd0, -1, 5'b0);
    check("dscore120", 32'(detail_score), 120);
    @(negedge clk);
    check("dvalid_one_cycle", 32'(detail_score_valid), 0);
    issue("mv", C_MV, 8'd0, 8'd0, -1, 5'b0);
    check("err_clean_flow", 32'(err), 0);
    issue("cd_after_video", C_CD, 8'd0, 8'd0, -1, 5'b0);

    // Illegal checks with missing prerequisites
    do_reset("rst_b");
    issue("cd_nogen", C_CD, 8'd0, 8'd0, -1, 5'b0);
    do_reset("rst_c");
    issue("mm_c", C_MM, 8'd10, 8'd0, -1, 5'b0);
    issue("cm_c", C_CM, 8'd0, 8'd0, -1, 5'b0);
    issue("mv_partial", C_MV, 8'd0, 8'd0, -1, 5'b0);

    // Command while busy, then simultaneous commands
    do_reset("rst_d");
    issue("mm_inj", C_MM, 8'd77, 8'd0, 1, C_MM);
    issue("cm_inj", C_CM, 8'd0, 8'd0, -1, 5'b0);
    do_reset("rst_e");
    issue("multi", C_MM | C_MD, 8'd5, 8'd6, -1, 5'b0);
    issue("md_after_multi", C_MD, 8'd0, 8'd255, 0, C_CD);
    issue("cd_after_multi", C_CD, 8'd0, 8'd0, -1, 5'b0);

    // Reset in the middle of render
    do_reset("rst_f");
    issue("f_mm", C_MM, 8'd1, 8'd0, -1, 5'b0);
    issue("f_cm", C_CM, 8'd0, 8'd0, -1, 5'b0);
    issue("f_md", C_MD, 8'd0, 8'd3, -1, 5'b0);
    issue("f_cd", C_CD, 8'd0, 8'd0, -1, 5'b0);
    drive(C_MV);
    @(negedge clk);
    drive(5'b0);
    repeat (3) @(negedge clk);
    check("f_render_busy", 32'(busy), 1);
    do_reset("rst_mid_render");
    repeat (RENDER_CYC) begin
      @(negedge clk);
      check("f_no_vdone", 32'(video_done), 0);
    end
    issue("f_cm_after_rst", C_CM, 8'd0, 8'd0, -1, 5'b0);

    // Random sequences, mostly protocol-progressing
    do_reset("rst_rand");
    for (int k = 0; k < 60; k++) begin
      r   = int'($urandom_range(0, 15));
      inj = 5'b0;
      if (r < 5) begin
        c = 5'b00001 << r;
      end else if (r == 5) begin
        a = int'($urandom_range(0, 4));
        b = (a + int'($urandom_range(1, 4))) % 5;
        c = (5'b00001 << a) | (5'b00001 << b);
      end else if (r == 6) begin
        do_reset("rst_rand_k");
        c = 5'b0;
      end else begin
        if (!m_mgen) c = C_MM;
        else if (!m_mchk) c = C_CM;
        else if (!m_dgen) c = C_MD;
        else if (!m_dchk) c = C_CD;
        else c = C_MV;
      end
      if ($urandom_range(0, 9) == 0) inj = 5'b00001 << $urandom_range(0, 4);
      if (c != 5'b0)
        issue("rand", c, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), inj);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
